// File: rtl/neuron_trainer.sv
// Online perceptron trainer: evaluates y = (W0*x0 + W1*x1 + B >= THRESH), applies perceptron rule on error.
// Define NEURON_TRAIN_SAT_EN to clamp updated weights/bias; otherwise they wrap modulo 2^WW.
module neuron_trainer #(
  parameter int unsigned XW                 = 4,
  parameter int unsigned WW                 = 6,
  parameter int unsigned ACCW               = 12,
  parameter logic signed [ACCW-1:0] THRESH  = ACCW'(6),
  parameter logic signed [WW-1:0]   W0_INIT = '0,
  parameter logic signed [WW-1:0]   W1_INIT = '0,
  parameter logic signed [WW-1:0]   B_INIT  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XW-1:0]        x0,
  input  logic [XW-1:0]        x1,
  input  logic                 target,
  input  logic                 learn_en,
  output logic                 out_valid,
  output logic                 y_pred,
  output logic                 err,
  output logic signed [WW-1:0] w0_out,
  output logic signed [WW-1:0] w1_out,
  output logic signed [WW-1:0] bias_out,
  output logic [7:0]           err_cnt
);

  localparam int unsigned SW = WW + XW + 1;
  localparam logic [XW-1:0] ONE = XW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [XW-1:0]         x0_q, x0_d;
  logic [XW-1:0]         x1_q, x1_d;
  logic                  tgt_q, tgt_d;
  logic                  learn_q, learn_d;
  logic                  y_q, y_d;
  logic                  err_q, err_d;
  logic                  ov_q, ov_d;
  logic signed [WW-1:0]  w0_q, w0_d;
  logic signed [WW-1:0]  w1_q, w1_d;
  logic signed [WW-1:0]  b_q, b_d;
  logic [7:0]            cnt_q, cnt_d;
  logic signed [ACCW-1:0] p0, p1, bext, acc;

`ifdef NEURON_TRAIN_SAT_EN
  localparam logic signed [SW-1:0] WMAX = {{(SW-WW+1){1'b0}}, {(WW-1){1'b1}}};
  localparam logic signed [SW-1:0] WMIN = {{(SW-WW+1){1'b1}}, {(WW-1){1'b0}}};
`endif

  function automatic logic signed [SW-1:0] step_w(input logic signed [WW-1:0] w,
                                                  input logic [XW-1:0] x,
                                                  input logic up);
    logic signed [SW-1:0] ws;
    logic signed [SW-1:0] xs;
    ws = $signed({{(SW-WW){w[WW-1]}}, w});
    xs = $signed({{(SW-XW){1'b0}}, x});
    step_w = up ? (ws + xs) : (ws - xs);
  endfunction

  function automatic logic signed [WW-1:0] reduce_w(input logic signed [SW-1:0] v);
`ifdef NEURON_TRAIN_SAT_EN
    if (v > WMAX)      reduce_w = $signed(WMAX[WW-1:0]);
    else if (v < WMIN) reduce_w = $signed(WMIN[WW-1:0]);
    else               reduce_w = $signed(v[WW-1:0]);
`else
    reduce_w = $signed(v[WW-1:0]);
`endif
  endfunction

  always_comb begin
    p0   = $signed({{(ACCW-WW){w0_q[WW-1]}}, w0_q}) * $signed({{(ACCW-XW){1'b0}}, x0_q});
    p1   = $signed({{(ACCW-WW){w1_q[WW-1]}}, w1_q}) * $signed({{(ACCW-XW){1'b0}}, x1_q});
    bext = $signed({{(ACCW-WW){b_q[WW-1]}}, b_q});
    acc  = p0 + p1 + bext;
  end

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    tgt_d   = tgt_q;
    learn_d = learn_q;
    y_d     = y_q;
    err_d   = err_q;
    ov_d    = 1'b0;
    w0_d    = w0_q;
    w1_d    = w1_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x0_d    = x0;
          x1_d    = x1;
          tgt_d   = target;
          learn_d = learn_en;
          state_d = EVAL;
        end
      end
      EVAL: begin
        y_d     = (acc >= THRESH);
        err_d   = (acc >= THRESH) ^ tgt_q;
        state_d = UPDATE;
      end
      UPDATE: begin
        if (err_q && learn_q) begin
          w0_d = reduce_w(step_w(w0_q, x0_q, tgt_q));
          w1_d = reduce_w(step_w(w1_q, x1_q, tgt_q));
          b_d  = reduce_w(step_w(b_q, ONE, tgt_q));
        end
        if (err_q && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
        ov_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      tgt_q   <= 1'b0;
      learn_q <= 1'b0;
      y_q     <= 1'b0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
      w0_q    <= W0_INIT;
      w1_q    <= W1_INIT;
      b_q     <= B_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      tgt_q   <= tgt_d;
      learn_q <= learn_d;
      y_q     <= y_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = ov_q;
  assign y_pred    = y_q;
  assign err       = err_q;
  assign w0_out    = w0_q;
  assign w1_out    = w1_q;
  assign bias_out  = b_q;
  assign err_cnt   = cnt_q;

endmodule
